seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Parametrised, time-multiplexed 7-segment display driver for the board's common-anode digit banks. It converts per-digit hex nibbles (or raw segment bytes) into scanned anode/segment drive. It adds what the combinational hex-to-segment converter lacks: an internal scan prescaler, an internal blink timer, frame-synchronous tear-free loading with a busy flag, and optional leading-zero suppression. It sits between the datapath/register display logic and the board's `AN`/`SEG` pins.

## Interface
- `DIGITS`, default 8: number of digits; legal range 2..16.
- `SCAN_DIV`, default 50000: clocks per digit slot; must be at least 2.
- `BLINK_DIV`, default 64: scan frames per blink half-period; must be at least 1.
- `ACTIVE_LOW`, default 1: when 1, `an` and `seg` are both active-low (every bit inverted).

- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load` in 1: single-cycle strobe that captures all data inputs.
- `hexs` in 4*DIGITS: hex nibbles; nibble i drives digit i, and digit 0 is the least significant.
- `points` in DIGITS: decimal-point enables, used in hex mode only.
- `les` in DIGITS: per-digit blink enables.
- `mode` in 1: 0 selects hex mode, 1 selects raw mode.
- `raw` in 8*DIGITS: raw segment bytes; byte i drives digit i in raw mode, in the `seg` bit order.
- `lz_en` in 1: leading-zero suppression, hex mode only.
- `an` out DIGITS: one-hot digit select.
- `seg` out 8: bit 7 is dp, bits 6..0 are segments g..a.
- `busy` out 1: high while a captured load is pending.
- `frame_done` out 1: one-cycle pulse at each frame wrap.
- `flash` out 1: current blink phase.

## Operation
- **Prescaler:** counts 0..SCAN_DIV-1. A tick occurs on the cycle where the count equals SCAN_DIV-1.
- **Digit index:** advances on each tick and wraps from DIGITS-1 to 0. The wrap is the frame boundary.
- **Frame counter:** counts frame boundaries 0..BLINK_DIV-1. `flash` toggles when the counter wraps.
- **Load capture:** on `load`, latch hexs/points/les/mode/raw/lz_en into the pending registers and set `busy`.
  - A further `load` while `busy` overwrites the pending registers; the last one wins.
  - At a frame boundary, a pending load is copied into the display registers and `busy` is cleared.
  - If `load` coincides with a frame boundary, the presented data goes straight to the display registers and `busy` stays 0.
- **Hex decode:** active-high gfedcba patterns for 0..F are 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71. dp is `points[i]`.
- **Raw mode:** `raw` byte i is used unchanged and `points` is ignored.
- **Leading-zero suppression:** with `lz_en` in hex mode, digits above the highest nonzero nibble are blank. Digit 0 is never suppressed.
- **Blinking:** a digit with `les[i]`=1 is blank while `flash`=1. Its anode keeps scanning.
- **Blank:** all segment bits off (seg=FF when ACTIVE_LOW). The ACTIVE_LOW inversion is applied last, to all bits of `an` and `seg`.

## Timing
- **Reset values (asynchronous):**
  - prescaler, digit index, frame counter: 0.
  - `flash`=0, `busy`=0, `frame_done`=0.
  - display and pending registers: 0.
  - `an` and `seg`: all off.
- **Output registration:** `an`/`seg` are registered from the current index and display registers.
  - The first clock after `rst` falls shows digit 0 with value "0".
  - Each index change appears on the outputs one clock later.
- **Frame length:** DIGITS*SCAN_DIV clocks. A blink half-period is BLINK_DIV frames.
- **`frame_done`:** registered; high for the one cycle after the index wraps to 0. A pending transfer is visible on `seg` in the same cycle.
- **`busy` latency:** rises the cycle after `load` and falls the cycle after the boundary.
- **Reset mid-frame:** aborts scanning and discards any pending load.

## Test plan
All scenarios use DIGITS=8, SCAN_DIV=4, BLINK_DIV=2, ACTIVE_LOW=1.

- **Reset:** assert `rst` mid-scan -> an=FF, seg=FF, busy=0, flash=0 immediately. One clock after release -> an=FE, seg=C0.
- **Basic load:** load hexs=12345678, points=00, les=00, mode=0 mid-frame -> busy=1 until the boundary, then 0. Digit 0 shows seg=80 with an=FE; digit 7 shows seg=F9 with an=7F; period is 32 clocks.
- **Blink:** les=0F -> `flash` toggles every 64 clocks. While flash=1, digits 0-3 give seg=FF with their anodes still asserted; digits 4-7 are unaffected.
- **Leading-zero suppression:** hexs=000000A5, lz_en=1 -> digit 0 seg=92, digit 1 seg=88, digits 2-7 seg=FF. hexs=0 -> digit 0 seg=C0, others FF.
- **Decimal point and raw mode:** mode=0, hexs=8, points=01 -> digit 0 seg=00. Then mode=1, raw byte0=06, points=FF -> digit 0 seg=F9 (points ignored).
- **Load collisions:** load on the boundary cycle -> new data shows on the next slot and busy stays 0. Two loads in one frame -> only the second is displayed.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scanner: prescaled digit scan, blink timer,
// frame-synchronous tear-free loading and optional leading-zero blanking.
module seg_scan_driver #(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 64,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   hexs,
    input  logic [DIGITS-1:0]     points,
    input  logic [DIGITS-1:0]     les,
    input  logic                  mode,
    input  logic [8*DIGITS-1:0]   raw,
    input  logic                  lz_en,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  flash
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [FW-1:0]     FRM_LAST   = FW'(BLINK_DIV - 1);
    localparam logic [DIGITS-1:0] AN_ONE     = DIGITS'(1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic [FW-1:0] frm;
    logic          tick;
    logic          wrap;

    logic [4*DIGITS-1:0] pend_hex, disp_hex;
    logic [DIGITS-1:0]   pend_pts, disp_pts;
    logic [DIGITS-1:0]   pend_les, disp_les;
    logic                pend_mode, disp_mode;
    logic [8*DIGITS-1:0] pend_raw, disp_raw;
    logic                pend_lz, disp_lz;

    logic [DIGITS-1:0] lz_blank;
    logic              upper_zero;
    logic [3:0]        nib;
    logic [7:0]        raw_byte;
    logic              digit_blank;
    logic [7:0]        seg_next;

    logic [DIGITS-1:0] an_p0;
    logic [7:0]        seg_p0;
    logic              wrap_p0;

    assign tick = (presc == PRESC_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Scan timing: prescaler, digit index, blink frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
            frm   <= '0;
            flash <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (wrap) begin
                frm <= (frm == FRM_LAST) ? '0 : frm + 1'b1;
                if (frm == FRM_LAST)
                    flash <= ~flash;
            end
        end
    end

    // Load path: pending registers swap into display only at a frame wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            pend_hex  <= '0;
            pend_pts  <= '0;
            pend_les  <= '0;
            pend_mode <= 1'b0;
            pend_raw  <= '0;
            pend_lz   <= 1'b0;
            disp_hex  <= '0;
            disp_pts  <= '0;
            disp_les  <= '0;
            disp_mode <= 1'b0;
            disp_raw  <= '0;
            disp_lz   <= 1'b0;
        end else if (load && wrap) begin
            busy      <= 1'b0;
            disp_hex  <= hexs;
            disp_pts  <= points;
            disp_les  <= les;
            disp_mode <= mode;
            disp_raw  <= raw;
            disp_lz   <= lz_en;
        end else begin
            if (load) begin
                busy      <= 1'b1;
                pend_hex  <= hexs;
                pend_pts  <= points;
                pend_les  <= les;
                pend_mode <= mode;
                pend_raw  <= raw;
                pend_lz   <= lz_en;
            end
            if (wrap && busy) begin
                busy      <= 1'b0;
                disp_hex  <= pend_hex;
                disp_pts  <= pend_pts;
                disp_les  <= pend_les;
                disp_mode <= pend_mode;
                disp_raw  <= pend_raw;
                disp_lz   <= pend_lz;
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero  = upper_zero && (disp_hex[4*i +: 4] == 4'h0);
            lz_blank[i] = upper_zero;
        end
    end

    always_comb begin
        nib         = disp_hex[{idx, 2'b00} +: 4];
        raw_byte    = disp_raw[{idx, 3'b000} +: 8];
        digit_blank = (disp_les[idx] && flash) ||
                      (!disp_mode && disp_lz && lz_blank[idx]);
        seg_next    = disp_mode ? raw_byte : {disp_pts[idx], hex_to_seg(nib)};
        if (digit_blank)
            seg_next = 8'h00;
    end

    // Output stage p0: registered active-high drive, frame_done aligned to digit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_p0      <= '0;
            seg_p0     <= '0;
            wrap_p0    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            an_p0      <= AN_ONE << idx;
            seg_p0     <= seg_next;
            wrap_p0    <= wrap;
            frame_done <= wrap_p0;
        end
    end

    assign an  = (ACTIVE_LOW != 0) ? ~an_p0  : an_p0;
    assign seg = (ACTIVE_LOW != 0) ? ~seg_p0 : seg_p0;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (8 digits, 4 clocks/slot, 2 frames/blink phase).
module tb_seg_scan_driver;

    localparam int K_SEG   = 0;
    localparam int K_BUSY  = 1;
    localparam int K_FLASH = 2;
    localparam int K_FD    = 3;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] expv;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] hexs = '0;
    logic [7:0]  points = '0;
    logic [7:0]  les = '0;
    logic        mode = 1'b0;
    logic [63:0] raw = '0;
    logic        lz_en = 1'b0;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        busy;
    logic        frame_done;
    logic        flash;

    int   cyc;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   done = 1'b0;
    bit   in_reset;
    exp_t sb[$];
    exp_t cur;
    logic [15:0] act;
    logic [7:0]  a_segs [8];

    seg_scan_driver #(
        .DIGITS(8),
        .SCAN_DIV(4),
        .BLINK_DIV(2),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .hexs(hexs),
        .points(points),
        .les(les),
        .mode(mode),
        .raw(raw),
        .lz_en(lz_en),
        .an(an),
        .seg(seg),
        .busy(busy),
        .frame_done(frame_done),
        .flash(flash)
    );

    always #5 clk = ~clk;

    // Clocks since reset release; edge n leaves cyc == n
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic void chk(input string name, input logic [15:0] a, input logic [15:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, a, e);
        end
    endfunction

    function automatic void push(input int c, input int k, input logic [15:0] v, input string nm);
        exp_t e;
        int   pos;
        e.cyc  = c;
        e.kind = k;
        e.expv = v;
        e.name = nm;
        pos = 0;
        while (pos < sb.size() && sb[pos].cyc <= c) pos++;
        sb.insert(pos, e);
    endfunction

    // Digit d of output frame f first appears after edge 32f+4d+1
    function automatic void exp_seg(input int f, input int d, input logic [7:0] s, input string nm);
        push(32*f + 4*d + 1, K_SEG, {~(8'h01 << d), s}, nm);
    endfunction

    function automatic void exp_bit(input int c, input int k, input logic b, input string nm);
        push(c, k, {15'd0, b}, nm);
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Strobe load so that it is captured by edge l
    task automatic do_load(input int l, input logic [31:0] h, input logic [7:0] p,
                           input logic [7:0] le, input logic m, input logic [63:0] r,
                           input logic lz);
        wait_cyc(l - 1);
        hexs   = h;
        points = p;
        les    = le;
        mode   = m;
        raw    = r;
        lz_en  = lz;
        load   = 1'b1;
        wait_cyc(l);
        load   = 1'b0;
    endtask

    // Monitor: pops expectations as the DUT reaches their cycle
    initial begin
        in_reset = 1'b1;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                if (!in_reset) begin
                    in_reset = 1'b1;
                    #1;
                    chk("async_rst_an",  {8'h00, an},  16'h00FF);
                    chk("async_rst_seg", {8'h00, seg}, 16'h00FF);
                    chk("async_rst_busy",  {15'd0, busy},       16'h0000);
                    chk("async_rst_flash", {15'd0, flash},      16'h0000);
                    chk("async_rst_fd",    {15'd0, frame_done}, 16'h0000);
                end
            end else begin
                in_reset = 1'b0;
                while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    cur = sb.pop_front();
                    if (cur.cyc < cyc) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL %s: missed at cycle %0d, due at cycle %0d", cur.name, cyc, cur.cyc);
                    end else begin
                        case (cur.kind)
                            K_SEG:   act = {an, seg};
                            K_BUSY:  act = {15'd0, busy};
                            K_FLASH: act = {15'd0, flash};
                            default: act = {15'd0, frame_done};
                        endcase
                        chk(cur.name, act, cur.expv);
                    end
                end
                if (done) begin
                    chk("sb_drained", 16'(sb.size()), 16'h0000);
                    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                    $finish;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        a_segs = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset display contents, scan order, frame_done timing
        exp_seg(0, 0, 8'hC0, "first_dig0");
        exp_seg(0, 7, 8'hC0, "f0_dig7");
        exp_seg(0, 3, 8'hC0, "tearfree_dig3");
        exp_bit(1,  K_FD, 1'b0, "fd_idle");
        exp_bit(32, K_FD, 1'b0, "fd_pre");
        exp_bit(33, K_FD, 1'b1, "fd_wrap");
        exp_bit(34, K_FD, 1'b0, "fd_single");

        // Basic load mid-frame
        exp_bit(9,  K_BUSY, 1'b0, "busy_before");
        exp_bit(10, K_BUSY, 1'b1, "busy_rise");
        exp_bit(31, K_BUSY, 1'b1, "busy_hold");
        exp_bit(32, K_BUSY, 1'b0, "busy_fall");
        for (int d = 0; d < 8; d++)
            exp_seg(1, d, a_segs[d], $sformatf("basic_dig%0d", d));
        exp_seg(2, 0, 8'h80, "basic_period");
        do_load(10, 32'h12345678, 8'h00, 8'h00, 1'b0, 64'h0, 1'b0);

        // Blink on low four digits
        exp_bit(63,  K_FLASH, 1'b0, "flash_lo");
        exp_bit(64,  K_FLASH, 1'b1, "flash_rise");
        exp_bit(127, K_FLASH, 1'b1, "flash_hold");
        exp_bit(128, K_FLASH, 1'b0, "flash_fall");
        exp_seg(3, 0, 8'hFF, "blink_dig0_off");
        exp_seg(3, 3, 8'hFF, "blink_dig3_off");
        exp_seg(3, 4, 8'h99, "blink_dig4_on");
        exp_seg(3, 7, 8'hF9, "blink_dig7_on");
        exp_seg(4, 0, 8'h80, "blink_dig0_back");
        exp_seg(4, 3, 8'h92, "blink_dig3_back");
        do_load(70, 32'h12345678, 8'h00, 8'h0F, 1'b0, 64'h0, 1'b0);

        // Leading-zero suppression
        exp_seg(5, 0, 8'h92, "lz_dig0");
        exp_seg(5, 1, 8'h88, "lz_dig1");
        exp_seg(5, 2, 8'hFF, "lz_dig2");
        exp_seg(5, 7, 8'hFF, "lz_dig7");
        do_load(140, 32'h000000A5, 8'h00, 8'h00, 1'b0, 64'h0, 1'b1);

        exp_seg(6, 0, 8'hC0, "lz_zero_dig0");
        exp_seg(6, 1, 8'hFF, "lz_zero_dig1");
        exp_seg(6, 7, 8'hFF, "lz_zero_dig7");
        do_load(170, 32'h00000000, 8'h00, 8'h00, 1'b0, 64'h0, 1'b1);

        // Decimal point, then raw mode ignoring points and lz_en
        exp_seg(7, 0, 8'h00, "dp_dig0");
        exp_seg(7, 1, 8'hC0, "dp_dig1");
        do_load(200, 32'h00000008, 8'h01, 8'h00, 1'b0, 64'h0, 1'b0);

        exp_seg(8, 0, 8'hF9, "raw_dig0");
        exp_seg(8, 1, 8'hC0, "raw_dig1");
        exp_seg(8, 2, 8'hFF, "raw_dig2");
        do_load(230, 32'h00000000, 8'hFF, 8'h00, 1'b1, 64'h0000_0000_0000_3F06, 1'b1);

        // Load on the frame boundary itself
        exp_bit(287, K_BUSY, 1'b0, "edge_busy_pre");
        exp_bit(288, K_BUSY, 1'b0, "edge_busy_at");
        exp_bit(289, K_BUSY, 1'b0, "edge_busy_post");
        exp_bit(289, K_FD,   1'b1, "edge_fd");
        exp_seg(9, 0, 8'hC0, "edge_dig0");
        exp_seg(9, 1, 8'hF9, "edge_dig1");
        exp_seg(9, 2, 8'hA4, "edge_dig2");
        do_load(288, 32'h76543210, 8'h00, 8'h00, 1'b0, 64'h0, 1'b0);

        // Two loads in one frame: last wins
        exp_bit(295, K_BUSY, 1'b1, "dbl_busy_first");
        exp_bit(300, K_BUSY, 1'b1, "dbl_busy_second");
        exp_bit(319, K_BUSY, 1'b1, "dbl_busy_hold");
        exp_bit(320, K_BUSY, 1'b0, "dbl_busy_fall");
        exp_seg(9, 3, 8'hB0, "dbl_tearfree_dig3");
        exp_seg(10, 0, 8'hA1, "dbl_dig0");
        exp_seg(10, 1, 8'hC0, "dbl_dig1");
        do_load(295, 32'h0000000E, 8'h00, 8'h00, 1'b0, 64'h0, 1'b0);
        do_load(300, 32'h0000000D, 8'h00, 8'h00, 1'b0, 64'h0, 1'b0);

        // Reset mid-frame with a pending load and flash high
        exp_bit(330, K_BUSY,  1'b1, "pend_busy");
        exp_bit(335, K_FLASH, 1'b1, "pre_rst_flash");
        do_load(330, 32'hFFFFFFFF, 8'hFF, 8'h00, 1'b0, 64'h0, 1'b0);
        wait_cyc(335);
        #5;
        rst = 1'b1;
        exp_seg(0, 0, 8'hC0, "post_rst_dig0");
        exp_seg(0, 7, 8'hC0, "post_rst_dig7");
        exp_bit(5,  K_BUSY,  1'b0, "post_rst_busy");
        exp_bit(32, K_BUSY,  1'b0, "post_rst_busy_wrap");
        exp_seg(1, 0, 8'hC0, "pend_discarded_dig0");
        exp_bit(40, K_FLASH, 1'b0, "post_rst_flash");
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cyc(40);
        done = 1'b1;
    end

endmodule
